// File: rtl/nv_nvdla_cmac_core_done_gen_if.sv
// Op-enable / atom-stream / completion signal bundle between the CMAC output
// stage, the register file and the done generator.
interface nv_nvdla_cmac_core_done_gen_if #(
    parameter int unsigned CNT_W = 22
);
    logic             reg2dp_op_en;
    logic [CNT_W-1:0] reg2dp_atomics;
    logic             out_pvld;
    logic             out_layer_end;
    logic             dp2reg_done;
    logic             op_busy;
    logic             cnt_err;
    logic [CNT_W-1:0] dp2reg_atom_cnt;

    // Register file / datapath side
    modport master (
        output reg2dp_op_en,
        output reg2dp_atomics,
        output out_pvld,
        output out_layer_end,
        input  dp2reg_done,
        input  op_busy,
        input  cnt_err,
        input  dp2reg_atom_cnt
    );

    // Done generator side
    modport slave (
        input  reg2dp_op_en,
        input  reg2dp_atomics,
        input  out_pvld,
        input  out_layer_end,
        output dp2reg_done,
        output op_busy,
        output cnt_err,
        output dp2reg_atom_cnt
    );
endinterface

// File: rtl/nv_nvdla_cmac_core_done_gen.sv
// CMAC layer-completion tracker: arms on an op_en start, counts output atoms,
// waits out the pipeline flush window, then pulses dp2reg_done for one cycle.
module nv_nvdla_cmac_core_done_gen #(
    parameter int unsigned CNT_W      = 22,
    parameter int unsigned DONE_DELAY = 2
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    nv_nvdla_cmac_core_done_gen_if.slave dg
);
    localparam int unsigned FLUSH_W = 4;
    localparam logic [FLUSH_W-1:0] FLUSH_INIT =
        (DONE_DELAY == 0) ? '0 : FLUSH_W'(DONE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_nxt;
    logic               op_en_d1;
    logic               done_d1;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic [FLUSH_W-1:0] flush_cnt_nxt;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   target_nxt;
    logic [CNT_W-1:0]   atom_cnt_q;
    logic [CNT_W-1:0]   atom_cnt_nxt;
    logic               cnt_err_q;
    logic               cnt_err_nxt;
    logic               done_q;
    logic               busy_q;

    logic               start;
    logic               cnt_hit;
    logic               last;

    // A start is an op_en rising edge, or op_en still high right after a done
    // so back-to-back layers need no op_en toggle.
    assign start   = dg.reg2dp_op_en & (~op_en_d1 | done_d1);
    assign cnt_hit = (atom_cnt_q == target_q);
    assign last    = dg.out_pvld & (cnt_hit | dg.out_layer_end);

    always_comb begin
        state_nxt     = state_q;
        flush_cnt_nxt = flush_cnt_q;
        target_nxt    = target_q;
        atom_cnt_nxt  = atom_cnt_q;
        cnt_err_nxt   = cnt_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    target_nxt   = dg.reg2dp_atomics;
                    atom_cnt_nxt = '0;
                    // An atom arriving with the start itself is stray, not atom 0.
                    cnt_err_nxt  = dg.out_pvld;
                end else if (dg.out_pvld) begin
                    cnt_err_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!dg.reg2dp_op_en) begin
                    state_nxt = IDLE;
                end else if (dg.out_pvld) begin
                    atom_cnt_nxt = atom_cnt_q + CNT_W'(1);
                    if (last) begin
                        if (cnt_hit != dg.out_layer_end) begin
                            cnt_err_nxt = 1'b1;
                        end
                        if (DONE_DELAY == 0) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = FLUSH_INIT;
                        end
                    end
                end
            end
            FLUSH: begin
                if (dg.out_pvld) begin
                    cnt_err_nxt = 1'b1;
                end
                if (!dg.reg2dp_op_en) begin
                    state_nxt = IDLE;
                end else if (flush_cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    flush_cnt_nxt = flush_cnt_q - FLUSH_W'(1);
                end
            end
            DONE: begin
                if (dg.out_pvld) begin
                    cnt_err_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; done/busy are registered decodes of the next state.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q     <= IDLE;
            op_en_d1    <= 1'b0;
            done_d1     <= 1'b0;
            flush_cnt_q <= '0;
            target_q    <= '0;
            atom_cnt_q  <= '0;
            cnt_err_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            op_en_d1    <= dg.reg2dp_op_en;
            done_d1     <= done_q;
            flush_cnt_q <= flush_cnt_nxt;
            target_q    <= target_nxt;
            atom_cnt_q  <= atom_cnt_nxt;
            cnt_err_q   <= cnt_err_nxt;
            done_q      <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    assign dg.dp2reg_done     = done_q;
    assign dg.op_busy         = busy_q;
    assign dg.cnt_err         = cnt_err_q;
    assign dg.dp2reg_atom_cnt = atom_cnt_q;

endmodule
